seq_divider: RTL
================

// Module: seq_divider
// PURPOSE
//  Sequential restoring shift-subtract unsigned divider.
//  It is the inverse companion of the shift-add multiplier and uses the same
//  valid_data/ack handshake and the same IDLE/CALC/DONE control structure.
//  It produces one quotient bit per clock and sits beside the multiplier in the
//  arithmetic datapath.
// PARAMETERS
//  WIDTH  32  operand, quotient and remainder width in bits (WIDTH >= 2)
// PORTS
//  Clock        in   1      single clock; all logic on posedge
//  Reset        in   1      synchronous, active-high; sampled only on posedge Clock
//  valid_data   in   1      operands valid; sampled only in IDLE
//  dividend     in   WIDTH  unsigned dividend; captured with valid_data
//  divisor      in   WIDTH  unsigned divisor; captured with valid_data
//  ack          in   1      result consumed; sampled only in DONE
//  busy         out  1      1 in CALC and DONE (not accepting new operands)
//  done         out  1      1 in DONE; result is valid
//  quotient     out  WIDTH  registered quotient
//  remainder    out  WIDTH  registered remainder
//  div_by_zero  out  1      1 with done when the captured divisor was 0
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0,
//   iteration counter=0. Reset wins over every other input on any cycle,
//   including mid-CALC. An in-flight operation is discarded and no done is issued.
//  Outputs: all outputs are registered. done and busy are Moore outputs decoded from state.
//  IDLE:
//   - valid_data=0: stay in IDLE.
//   - valid_data=1 and divisor!=0: latch operands; rem=0; quo=dividend;
//     cnt=0; div_by_zero=0; go to CALC.
//   - valid_data=1 and divisor==0: quotient={WIDTH{1'b1}}; remainder=dividend;
//     div_by_zero=1; go directly to DONE (done rises on the next cycle).
//  CALC: one iteration per cycle, WIDTH iterations exactly:
//   - t = {rem, quo[WIDTH-1]} (WIDTH+1 bits); quo is shifted left by 1.
//   - t >= {1'b0,divisor}: rem = t - divisor and new quo LSB = 1.
//   - otherwise: rem = t[WIDTH-1:0] and new quo LSB = 0.
//   - cnt increments; after the iteration where cnt==WIDTH-1, load
//     quotient/remainder and go to DONE.
//   - The counter is $clog2(WIDTH)+1 bits wide. The subtract is WIDTH+1 bits
//     wide, so there is no overflow.
//   - valid_data and ack are ignored in CALC.
//  Latency:
//   - Accept edge = E. done is high from edge E+WIDTH+1 (33 cycles for WIDTH=32).
//   - Divide-by-zero case: done is high from edge E+1.
//  DONE:
//   - done=1, and quotient, remainder and div_by_zero hold stable until ack=1 is
//     sampled. The next state is then IDLE, and done and busy drop on that edge.
//   - valid_data in DONE is ignored, even in the same cycle as ack. A new
//     operation is accepted no earlier than the first IDLE cycle.
//  After ack: quotient and remainder keep their values until the next accept.
//   div_by_zero clears on the next accept.
//  Illegal state encoding: return to IDLE on the next edge with all outputs cleared.
// TESTING
//  1. 100/7 -> 33 cycles after accept: done=1, quotient=14, remainder=2, div_by_zero=0.
//  2. 55/0 -> done=1 one cycle after accept; quotient=32'hFFFFFFFF, remainder=55,
//     div_by_zero=1.
//  3. Corner cases:
//     - 32'hFFFFFFFF/1 -> quotient=32'hFFFFFFFF, remainder=0.
//     - 5/9 -> quotient=0, remainder=5.
//     - 9/9 -> quotient=1, remainder=0.
//  4. Hold ack=0 for 10 cycles in DONE and pulse valid_data during CALC/DONE with
//     new operands:
//     - outputs stay constant and no extra operation starts;
//     - ack=1 -> done=0 on the next cycle.
//  5. Assert Reset=1 at iteration 10 of CALC:
//     - next cycle: IDLE with all outputs 0;
//     - a new 100/7 request completes correctly.
//  6. ack and valid_data high together in DONE:
//     - the valid_data is ignored;
//     - valid_data held in the following IDLE cycle is accepted, and done follows
//       WIDTH+1 cycles later.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential restoring shift-subtract unsigned divider: one quotient bit per clock,
// valid_data/ack handshake, IDLE/CALC/DONE control.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             valid_data,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_rem, w_rem_nxt;
  logic [WIDTH-1:0] r_quo, w_quo_nxt;
  logic [WIDTH-1:0] r_dvs, w_dvs_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_quotient, w_quotient_nxt;
  logic [WIDTH-1:0] r_remainder, w_remainder_nxt;
  logic             r_dbz, w_dbz_nxt;
  logic             r_busy, r_done;
  logic             w_busy_nxt, w_done_nxt;

  logic [WIDTH:0]   w_t;
  logic [WIDTH:0]   w_sub;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_step;
  logic [WIDTH-1:0] w_quo_step;

  // Since rem < divisor always holds, t < 2*divisor and t - divisor < 2^WIDTH:
  // the MSB of the (WIDTH+1)-bit difference is therefore exactly the borrow.
  assign w_t        = {r_rem, r_quo[WIDTH-1]};
  assign w_sub      = w_t - {1'b0, r_dvs};
  assign w_ge       = ~w_sub[WIDTH];
  assign w_rem_step = w_ge ? w_sub[WIDTH-1:0] : w_t[WIDTH-1:0];
  assign w_quo_step = {r_quo[WIDTH-2:0], w_ge};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_rem_nxt       = r_rem;
    w_quo_nxt       = r_quo;
    w_dvs_nxt       = r_dvs;
    w_cnt_nxt       = r_cnt;
    w_quotient_nxt  = r_quotient;
    w_remainder_nxt = r_remainder;
    w_dbz_nxt       = r_dbz;
    case (r_state)
      S_IDLE: begin
        if (valid_data) begin
          if (divisor != '0) begin
            w_dvs_nxt   = divisor;
            w_rem_nxt   = '0;
            w_quo_nxt   = dividend;
            w_cnt_nxt   = '0;
            w_dbz_nxt   = 1'b0;
            w_state_nxt = S_CALC;
          end else begin
            w_quotient_nxt  = '1;
            w_remainder_nxt = dividend;
            w_dbz_nxt       = 1'b1;
            w_state_nxt     = S_DONE;
          end
        end
      end
      S_CALC: begin
        w_rem_nxt = w_rem_step;
        w_quo_nxt = w_quo_step;
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_quotient_nxt  = w_quo_step;
          w_remainder_nxt = w_rem_step;
          w_state_nxt     = S_DONE;
        end
      end
      S_DONE: begin
        if (ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_rem_nxt       = '0;
        w_quo_nxt       = '0;
        w_dvs_nxt       = '0;
        w_cnt_nxt       = '0;
        w_quotient_nxt  = '0;
        w_remainder_nxt = '0;
        w_dbz_nxt       = 1'b0;
      end
    endcase
    w_busy_nxt = (w_state_nxt == S_CALC) || (w_state_nxt == S_DONE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // busy/done are registered from the next state so they track r_state exactly.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_rem       <= w_rem_nxt;
      r_quo       <= w_quo_nxt;
      r_dvs       <= w_dvs_nxt;
      r_cnt       <= w_cnt_nxt;
      r_quotient  <= w_quotient_nxt;
      r_remainder <= w_remainder_nxt;
      r_dbz       <= w_dbz_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule
